// File: rtl/block_lock_ctrl.sv
// Per-lane block-lock controller: steps the alignment shifter OFFSET until the
// 2-bit sync headers validate, then declares and supervises block lock.
module block_lock_ctrl #(
    parameter int DATA_WIDTH = 80,
    parameter int HDR_LSB    = 64,
    parameter int MAX_OFFSET = 63,
    parameter int LOCK_CNT   = 64,
    parameter int WINDOW     = 64,
    parameter int ERR_LIMIT  = 16,
    parameter int SLIP_WAIT  = 3
) (
    input  logic                  USER_CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  DATA_VALID,
    input  logic                  INVERT,
    output logic [5:0]            OFFSET,
    output logic [DATA_WIDTH-1:0] MASK,
    output logic                  BLOCK_LOCK,
    output logic [7:0]            LOCK_LOSS_CNT
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int SW = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        ST_SLIP_WAIT = 2'd0,
        ST_HUNT      = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   wait_cnt;
    logic [GW-1:0]   good_cnt;
    logic [WW-1:0]   win_cnt;
    logic [EW-1:0]   err_cnt;
    logic            invert_p0;
    logic            invert_p1;

    logic [1:0]      hdr;
    logic            hdr_ok;
    logic            inv_chg;
    logic [GW-1:0]   good_nxt;
    logic [WW-1:0]   win_nxt;
    logic [EW-1:0]   err_nxt;
    logic            unused_data;

    function automatic logic hdr_valid(input logic [1:0] h);
        return h[1] ^ h[0];
    endfunction

    function automatic logic [5:0] slip_offset(input logic [5:0] off);
        return (off == 6'(MAX_OFFSET)) ? 6'd0 : off + 6'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign hdr         = DATA_IN[HDR_LSB+1:HDR_LSB];
    assign hdr_ok      = hdr_valid(hdr);
    assign inv_chg     = invert_p0 ^ invert_p1;
    assign good_nxt    = good_cnt + GW'(1);
    assign win_nxt     = win_cnt + WW'(1);
    assign err_nxt     = err_cnt + EW'(!hdr_ok);
    assign unused_data = ^{DATA_IN[DATA_WIDTH-1:HDR_LSB+2], DATA_IN[HDR_LSB-1:0]};

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= ST_SLIP_WAIT;
            wait_cnt      <= '0;
            good_cnt      <= '0;
            win_cnt       <= '0;
            err_cnt       <= '0;
            invert_p0     <= 1'b0;
            invert_p1     <= 1'b0;
            OFFSET        <= '0;
            MASK          <= '0;
            BLOCK_LOCK    <= 1'b0;
            LOCK_LOSS_CNT <= '0;
        end else begin
            // MASK tracks the once-registered INVERT; the second flop feeds edge detect
            invert_p0 <= INVERT;
            invert_p1 <= invert_p0;
            MASK      <= {DATA_WIDTH{INVERT}};

            if (inv_chg) begin
                // Polarity changed under us: restart alignment at the same OFFSET
                if (state == ST_LOCKED) begin
                    LOCK_LOSS_CNT <= sat_inc8(LOCK_LOSS_CNT);
                end
                BLOCK_LOCK <= 1'b0;
                wait_cnt   <= '0;
                good_cnt   <= '0;
                win_cnt    <= '0;
                err_cnt    <= '0;
                state      <= ST_SLIP_WAIT;
            end else begin
                case (state)
                    ST_SLIP_WAIT: begin
                        if (wait_cnt == SW'(SLIP_WAIT - 1)) begin
                            wait_cnt <= '0;
                            good_cnt <= '0;
                            state    <= ST_HUNT;
                        end else begin
                            wait_cnt <= wait_cnt + SW'(1);
                        end
                    end

                    ST_HUNT: begin
                        if (DATA_VALID) begin
                            if (!hdr_ok) begin
                                OFFSET   <= slip_offset(OFFSET);
                                good_cnt <= '0;
                                wait_cnt <= '0;
                                state    <= ST_SLIP_WAIT;
                            end else if (good_nxt == GW'(LOCK_CNT)) begin
                                good_cnt   <= '0;
                                win_cnt    <= '0;
                                err_cnt    <= '0;
                                BLOCK_LOCK <= 1'b1;
                                state      <= ST_LOCKED;
                            end else begin
                                good_cnt <= good_nxt;
                            end
                        end
                    end

                    ST_LOCKED: begin
                        if (DATA_VALID) begin
                            // Error limit wins even on the last word of a window
                            if (err_nxt == EW'(ERR_LIMIT)) begin
                                BLOCK_LOCK    <= 1'b0;
                                LOCK_LOSS_CNT <= sat_inc8(LOCK_LOSS_CNT);
                                OFFSET        <= slip_offset(OFFSET);
                                win_cnt       <= '0;
                                err_cnt       <= '0;
                                wait_cnt      <= '0;
                                state         <= ST_SLIP_WAIT;
                            end else if (win_nxt == WW'(WINDOW)) begin
                                win_cnt <= '0;
                                err_cnt <= '0;
                            end else begin
                                win_cnt <= win_nxt;
                                err_cnt <= err_nxt;
                            end
                        end
                    end

                    default: begin
                        wait_cnt <= '0;
                        state    <= ST_SLIP_WAIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_block_lock_ctrl.sv
// Randomized bench for block_lock_ctrl against an abstract lane-alignment model.
module tb_block_lock_ctrl;

    localparam int W = 80;

    logic          USER_CLK = 1'b0;
    logic          RESET_N;
    logic [W-1:0]  DATA_IN;
    logic          DATA_VALID;
    logic          INVERT;
    logic [5:0]    OFFSET;
    logic [W-1:0]  MASK;
    logic          BLOCK_LOCK;
    logic [7:0]    LOCK_LOSS_CNT;

    block_lock_ctrl dut (
        .USER_CLK      (USER_CLK),
        .RESET_N       (RESET_N),
        .DATA_IN       (DATA_IN),
        .DATA_VALID    (DATA_VALID),
        .INVERT        (INVERT),
        .OFFSET        (OFFSET),
        .MASK          (MASK),
        .BLOCK_LOCK    (BLOCK_LOCK),
        .LOCK_LOSS_CNT (LOCK_LOSS_CNT)
    );

    always #5 USER_CLK = ~USER_CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: lane is either waiting out a slip, hunting, or locked
    int m_off, m_loss, m_wait_left, m_good, m_win, m_err;
    bit m_locked, m_inv_r, m_inv_q;

    task automatic m_enter_wait();
        m_wait_left = 3;
        m_good = 0;
        m_win = 0;
        m_err = 0;
    endtask

    task automatic m_slip();
        m_off = (m_off + 1) % 64;
        m_enter_wait();
    endtask

    task automatic m_lose();
        if (m_loss < 255) m_loss++;
        m_locked = 0;
    endtask

    task automatic model_reset();
        m_off = 0; m_loss = 0; m_locked = 0; m_inv_r = 0; m_inv_q = 0;
        m_enter_wait();
    endtask

    task automatic model_step(input logic v, input logic [1:0] hdr, input logic inv);
        bit chg = (m_inv_r != m_inv_q);
        bit ok = (hdr == 2'b01) || (hdr == 2'b10);
        m_inv_q = m_inv_r;
        m_inv_r = inv;
        if (chg) begin
            if (m_locked) m_lose();
            m_enter_wait();
        end else if (m_wait_left > 0) begin
            m_wait_left--;
        end else if (v) begin
            if (!m_locked) begin
                if (!ok) m_slip();
                else begin
                    m_good++;
                    if (m_good == 64) begin
                        m_locked = 1; m_win = 0; m_err = 0;
                    end
                end
            end else begin
                m_win++;
                if (!ok) m_err++;
                if (m_err == 16) begin
                    m_lose();
                    m_slip();
                end else if (m_win == 64) begin
                    m_win = 0; m_err = 0;
                end
            end
        end
    endtask

    // Stimulus knobs: aligned offset (-1 = none), bad headers per window, valid duty
    int good_off = 0;
    int bad_per_win = 0;
    int valid_pct = 100;
    int wc = 0;
    int edge_n = 0;

    task automatic drive();
        logic [95:0] r;
        logic [1:0]  h;
        bit bad;
        r = {$urandom, $urandom, $urandom};
        DATA_VALID = ($urandom_range(99) < valid_pct);
        if (!BLOCK_LOCK) wc = 0;
        bad = (int'(OFFSET) != good_off);
        if (!bad && BLOCK_LOCK && DATA_VALID) begin
            bad = ((wc % 64) < bad_per_win);
            wc++;
        end
        if (bad) h = $urandom_range(1) ? 2'b11 : 2'b00;
        else     h = $urandom_range(1) ? 2'b01 : 2'b10;
        DATA_IN = r[W-1:0];
        DATA_IN[65:64] = h;
    endtask

    task automatic cycle();
        @(posedge USER_CLK);
        model_step(DATA_VALID, DATA_IN[65:64], INVERT);
        edge_n++;
        #1;
        check("offset", W'(OFFSET), W'(m_off));
        check("mask", MASK, {W{m_inv_r}});
        check("block_lock", W'(BLOCK_LOCK), W'(m_locked));
        check("loss_cnt", W'(LOCK_LOSS_CNT), W'(m_loss));
        drive();
    endtask

    task automatic apply_reset();
        #2 RESET_N = 1'b0;
        #1;
        check("rst_offset", W'(OFFSET), '0);
        check("rst_mask", MASK, '0);
        check("rst_lock", W'(BLOCK_LOCK), '0);
        check("rst_loss", W'(LOCK_LOSS_CNT), '0);
        model_reset();
        @(posedge USER_CLK);
        @(posedge USER_CLK);
        #1 RESET_N = 1'b1;
        edge_n = 0;
        drive();
    endtask

    task automatic run_until_lock(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (BLOCK_LOCK) begin
                at = edge_n;
                break;
            end
        end
        if (at < 0) check("lock_timeout", '0, W'(1));
    endtask

    int lock_at;
    int prev_off;
    bit wrapped;
    bit seen_lock;

    initial begin
        RESET_N = 1'b0;
        INVERT = 1'b0;
        DATA_VALID = 1'b0;
        DATA_IN = '0;
        @(posedge USER_CLK);
        @(posedge USER_CLK);
        #1;
        check("init_offset", W'(OFFSET), '0);
        check("init_mask", MASK, '0);
        check("init_lock", W'(BLOCK_LOCK), '0);
        check("init_loss", W'(LOCK_LOSS_CNT), '0);
        model_reset();
        RESET_N = 1'b1;
        drive();

        // Aligned at offset 0
        run_until_lock(200, lock_at);
        check("t1_lock_edge", W'(lock_at), W'(67));
        check("t1_offset", W'(OFFSET), '0);

        // Alignment at offset 5
        good_off = 5;
        apply_reset();
        run_until_lock(300, lock_at);
        check("t2_lock_edge", W'(lock_at), W'(87));
        check("t2_offset", W'(OFFSET), W'(5));
        check("t2_loss", W'(LOCK_LOSS_CNT), '0);

        // 15 bad per window keeps lock; 16 drops it
        bad_per_win = 15;
        for (int i = 0; i < 192; i++) cycle();
        check("t3_hold", W'(BLOCK_LOCK), W'(1));
        bad_per_win = 16;
        for (int i = 0; i < 200 && BLOCK_LOCK; i++) cycle();
        check("t3_dropped", W'(BLOCK_LOCK), '0);
        check("t3_offset", W'(OFFSET), W'(6));
        check("t3_loss", W'(LOCK_LOSS_CNT), W'(1));
        bad_per_win = 0;
        run_until_lock(600, lock_at);
        check("t3_relock_offset", W'(OFFSET), W'(5));

        // No valid alignment anywhere: full sweep with wrap, never locks
        good_off = -1;
        apply_reset();
        wrapped = 0;
        seen_lock = 0;
        prev_off = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (prev_off == 63 && OFFSET == 6'd0) wrapped = 1;
            if (BLOCK_LOCK) seen_lock = 1;
            prev_off = int'(OFFSET);
        end
        check("t4_wrapped", W'(wrapped), W'(1));
        check("t4_never_locked", W'(seen_lock), '0);

        // INVERT toggle while locked
        good_off = 0;
        apply_reset();
        run_until_lock(200, lock_at);
        INVERT = 1'b1;
        cycle();
        check("t5_mask_ones", MASK, {W{1'b1}});
        cycle();
        check("t5_lock_drop", W'(BLOCK_LOCK), '0);
        run_until_lock(200, lock_at);
        check("t5_offset", W'(OFFSET), '0);
        check("t5_loss", W'(LOCK_LOSS_CNT), W'(1));

        // 50% DATA_VALID duty
        valid_pct = 50;
        apply_reset();
        run_until_lock(600, lock_at);
        check("t6_locked", W'(BLOCK_LOCK), W'(1));

        // Move to offset 3 and reset mid-HUNT
        good_off = 3;
        for (int i = 0; i < 800 && OFFSET != 6'd3; i++) cycle();
        for (int i = 0; i < 10; i++) cycle();
        check("t6_pre_reset_offset", W'(OFFSET), W'(3));
        check("t6_pre_reset_hunt", W'(BLOCK_LOCK), '0);
        apply_reset();
        for (int i = 0; i < 20; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
